// File: rtl/divide_arbiter.sv
// rtl/divide_arbiter.sv - round-robin arbiter sharing one pipelined divider with in-order result routing
module divide_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_numer_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_denom_i,
    output logic [N_REQ-1:0]              resp_valid_o,
    input  logic [N_REQ-1:0]              resp_ready_i,
    output logic [DATA_WIDTH-1:0]         resp_quotient_o,
    output logic [DATA_WIDTH-1:0]         resp_remain_o,
    output logic                          resp_dbz_o,
    input  logic                          div_ready_in_i,
    output logic                          div_valid_in_o,
    output logic [DATA_WIDTH-1:0]         div_numer_in_o,
    output logic [DATA_WIDTH-1:0]         div_denom_in_o,
    output logic                          div_ready_out_o,
    input  logic                          div_valid_out_i,
    input  logic [DATA_WIDTH-1:0]         div_quotient_i,
    input  logic [DATA_WIDTH-1:0]         div_remain_i,
    output logic [$clog2(TAG_DEPTH):0]    inflight_o,
    output logic                          tag_err_o
);
    localparam int REQ_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tag_err_q, tag_err_d;

    logic [REQ_W-1:0] tag_owner_q [TAG_DEPTH];
    logic             tag_dbz_q   [TAG_DEPTH];

    logic [REQ_W-1:0] grant_idx;
    logic             issue;
    logic             pop;
    logic             has_tag;
    logic             full;
    logic [REQ_W-1:0] head_owner;
    logic             grant_dbz;

    // Round-robin search starting at rr_ptr; descending loop lets the nearest requester win.
    always_comb begin
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(rr_ptr_q) + k) % N_REQ]) begin
                grant_idx = REQ_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    assign has_tag    = (count_q != '0);
    assign full       = (count_q == CNT_W'(TAG_DEPTH));
    assign head_owner = tag_owner_q[rd_ptr_q];
    assign grant_dbz  = (req_denom_i[grant_idx*DATA_WIDTH +: DATA_WIDTH] == '0);

    // Issue is masked during reset so no request is acknowledged while state is being cleared.
    assign issue = rst_ni & (|req_valid_i) & div_ready_in_i & ~full;
    assign pop   = div_valid_out_i & has_tag & resp_ready_i[head_owner];

    assign req_ready_o     = issue ? (N_REQ'(1) << grant_idx) : '0;
    assign div_valid_in_o  = issue;
    assign div_numer_in_o  = req_numer_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign div_denom_in_o  = req_denom_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    assign resp_valid_o    = (div_valid_out_i & has_tag) ? (N_REQ'(1) << head_owner) : '0;
    assign resp_quotient_o = div_quotient_i;
    assign resp_remain_o   = div_remain_i;
    assign resp_dbz_o      = tag_dbz_q[rd_ptr_q];
    // With no tag outstanding any divider output is stray, so accept it to keep the pipe draining.
    assign div_ready_out_o = has_tag ? resp_ready_i[head_owner] : 1'b1;

    assign inflight_o = count_q;
    assign tag_err_o  = tag_err_q;

    // Next-state for arbitration pointer, tag FIFO pointers/occupancy and sticky error.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tag_err_d = tag_err_q;
        if (issue) begin
            rr_ptr_d = (grant_idx == REQ_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (div_valid_out_i && !has_tag) begin
            tag_err_d = 1'b1;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tag_err_q <= tag_err_d;
        end
    end

    // Tag storage: owner and divide-by-zero flag of each issued operation, read back in order.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            tag_owner_q[wr_ptr_q] <= grant_idx;
            tag_dbz_q[wr_ptr_q]   <= grant_dbz;
        end
    end
endmodule

// File: tb/tb_divide_arbiter.sv
// tb/tb_divide_arbiter.sv - scoreboard bench for divide_arbiter with a latency-3 divider model
module tb_divide_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TD  = 8;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_numer = '0;
    logic [N*DW-1:0] req_denom = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '1;
    logic [DW-1:0]   resp_quotient, resp_remain;
    logic            resp_dbz;
    logic            div_ready_in, div_valid_in, div_ready_out, div_valid_out;
    logic [DW-1:0]   div_numer_in, div_denom_in, div_quotient, div_remain;
    logic [3:0]      inflight;
    logic            tag_err;
    logic            force_vld = 1'b0;

    divide_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_numer_i(req_numer), .req_denom_i(req_denom),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_quotient_o(resp_quotient), .resp_remain_o(resp_remain), .resp_dbz_o(resp_dbz),
        .div_ready_in_i(div_ready_in), .div_valid_in_o(div_valid_in),
        .div_numer_in_o(div_numer_in), .div_denom_in_o(div_denom_in),
        .div_ready_out_o(div_ready_out), .div_valid_out_i(div_valid_out),
        .div_quotient_i(div_quotient), .div_remain_i(div_remain),
        .inflight_o(inflight), .tag_err_o(tag_err)
    );

    always #5 clk = ~clk;

    // Divider model: 16-entry elastic queue, each result valid LAT cycles after issue.
    logic [DW-1:0] m_n [16];
    logic [DW-1:0] m_d [16];
    int            m_t [16];
    logic [3:0]    m_wr, m_rd;
    logic [4:0]    m_cnt;
    int            cyc;
    logic          m_head_vld, m_push, m_pop;

    assign m_head_vld   = (m_cnt != 0) && (cyc >= m_t[m_rd] + LAT);
    assign div_ready_in = (m_cnt < 5'd16);
    assign div_valid_out = m_head_vld | force_vld;
    assign div_quotient = (m_d[m_rd] != 0) ? m_n[m_rd] / m_d[m_rd] : '0;
    assign div_remain   = (m_d[m_rd] != 0) ? m_n[m_rd] % m_d[m_rd] : '0;
    assign m_push       = div_valid_in && div_ready_in;
    assign m_pop        = m_head_vld && div_ready_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr <= '0; m_rd <= '0; m_cnt <= '0; cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_push) begin
                m_n[m_wr] <= div_numer_in;
                m_d[m_wr] <= div_denom_in;
                m_t[m_wr] <= cyc;
                m_wr      <= m_wr + 1'b1;
            end
            if (m_pop) m_rd <= m_rd + 1'b1;
            m_cnt <= m_cnt + 5'(m_push) - 5'(m_pop);
        end
    end

    typedef struct { int owner; logic [DW-1:0] q; logic [DW-1:0] r; logic dbz; } exp_t;
    exp_t sb[$];

    logic [DW-1:0] op_n [N];
    logic [DW-1:0] op_q [N];
    logic [DW-1:0] op_r [N];
    logic          op_dbz [N];
    int rr_m = 0;
    int n_grants = 0;
    int max_if = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] n, input logic [DW-1:0] d,
                          input logic [DW-1:0] q, input logic [DW-1:0] r, input logic z);
        req_numer[i*DW +: DW] = n;
        req_denom[i*DW +: DW] = d;
        op_n[i] = n; op_q[i] = q; op_r[i] = r; op_dbz[i] = z;
    endtask

    // Monitor: checks grants against a round-robin model and pops the scoreboard on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(inflight) > max_if) max_if = int'(inflight);
            if (|req_ready) begin
                int g;
                exp_t e;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
                end
                if (g < 0) g = 0;
                check("grant", req_ready, 64'(1) << g);
                check("issue_numer", div_numer_in, op_n[g]);
                e.owner = g; e.q = op_q[g]; e.r = op_r[g]; e.dbz = op_dbz[g];
                sb.push_back(e);
                rr_m = (g + 1) % N;
                n_grants++;
            end
            if (|(resp_valid & resp_ready)) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_owner", resp_valid, 64'(1) << e.owner);
                    check("resp_dbz", resp_dbz, e.dbz);
                    if (!e.dbz) begin
                        check("resp_q", resp_quotient, e.q);
                        check("resp_r", resp_remain, e.r);
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int k = 0; k < 300; k++) begin
            if (sb.size() == 0 && inflight == 0) break;
            @(posedge clk); #1;
        end
        check(name, (sb.size() == 0 && inflight == 0), 1);
    endtask

    initial begin
        int g0;
        for (int i = 0; i < N; i++) set_op(i, 100 + i * 7, 7, 14 + i, 2, 1'b0);
        req_valid = '1;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_div_valid_in", div_valid_in, 0);
        check("rst_inflight", inflight, 0);
        check("rst_tag_err", tag_err, 0);
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: all requesters continuously valid, no backpressure
        @(posedge clk); #1;
        g0 = n_grants;
        req_valid = '1;
        repeat (12) @(posedge clk);
        #1 req_valid = '0;
        check("t1_grants", n_grants - g0, 12);
        drain("t1_drain");

        // 2: single divide-by-zero request from requester 2
        set_op(2, 9, 0, 0, 0, 1'b1);
        g0 = n_grants;
        req_valid = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (n_grants > g0) break;
        end
        req_valid = '0;
        check("t2_grants", n_grants - g0, 1);
        drain("t2_drain");
        set_op(2, 114, 7, 16, 2, 1'b0);

        // 3/4: requester 1 stalls its result, FIFO fills, then release with requests still pending
        max_if = 0;
        resp_ready = 4'b1101;
        req_valid = '1;
        repeat (20) @(posedge clk);
        #1;
        check("t3_inflight_full", inflight, TD);
        check("t3_req_ready", req_ready, 0);
        check("t3_div_ready_out", div_ready_out, 0);
        check("t3_resp_valid", resp_valid, 4'b0010);
        resp_ready = '1;
        repeat (6) @(posedge clk);
        #1 req_valid = '0;
        drain("t3_drain");
        check("t4_max_inflight", max_if, TD);

        // 5: stray divider result with no tag outstanding
        force_vld = 1'b1;
        #1;
        check("t5_resp_valid", resp_valid, 0);
        check("t5_div_ready_out", div_ready_out, 1);
        @(posedge clk); #1 force_vld = 1'b0;
        check("t5_tag_err", tag_err, 1);
        repeat (5) @(posedge clk);
        #1 check("t5_tag_err_sticky", tag_err, 1);

        // 6: asynchronous reset with three operations in flight
        resp_ready = '0;
        req_valid = 4'b0111;
        repeat (3) @(posedge clk);
        #2 check("t6_inflight_pre", inflight, 3);
        rst_n = 1'b0;
        #1;
        check("t6_req_ready", req_ready, 0);
        check("t6_resp_valid", resp_valid, 0);
        check("t6_inflight", inflight, 0);
        check("t6_tag_err", tag_err, 0);
        sb.delete();
        rr_m = 0;
        req_valid = '0;
        resp_ready = '1;
        @(posedge clk); #1 rst_n = 1'b1;

        // Post-reset: arbitration restarts at requester 0
        g0 = n_grants;
        req_valid = '1;
        @(posedge clk); #1 req_valid = '0;
        check("t6_post_grants", n_grants - g0, 1);
        drain("t6_post_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
